seg_scan_driver: RTL and testbench

Eight-digit multiplexed seven-segment driver sitting directly downstream of the countdown/mode blocks: it takes a packed 8-nibble display word and scans it onto the board's two 4-digit segment buses plus an 8-bit tube select. It latches the word once per frame so that digits never tear mid-scan. It also provides per-digit blinking for setting screens and a global display enable.

---
 rtl/seg_scan_driver_pkg.sv | 35 +++
 rtl/seg_scan_driver_seg7_decode.sv | 32 +++
 rtl/seg_scan_driver.sv | 98 +++++++++
 tb/tb_seg_scan_driver.sv | 135 +++++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared display codes: segment patterns ({a,b,c,d,e,f,g,dp}, active high) and special nibbles.
package seg_scan_driver_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned WORD_W     = NUM_DIGITS * NIB_W;

    localparam logic [SEG_W-1:0] SEG_0     = 8'hFC;
    localparam logic [SEG_W-1:0] SEG_1     = 8'h60;
    localparam logic [SEG_W-1:0] SEG_2     = 8'hDA;
    localparam logic [SEG_W-1:0] SEG_3     = 8'hF2;
    localparam logic [SEG_W-1:0] SEG_4     = 8'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 8'hB6;
    localparam logic [SEG_W-1:0] SEG_6     = 8'hBE;
    localparam logic [SEG_W-1:0] SEG_7     = 8'hE0;
    localparam logic [SEG_W-1:0] SEG_8     = 8'hFE;
    localparam logic [SEG_W-1:0] SEG_9     = 8'hF6;
    localparam logic [SEG_W-1:0] SEG_A     = 8'hEE;
    localparam logic [SEG_W-1:0] SEG_B     = 8'h3E;
    localparam logic [SEG_W-1:0] SEG_C     = 8'h9C;
    localparam logic [SEG_W-1:0] SEG_D     = 8'h7A;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;
    localparam logic [SEG_W-1:0] SEG_DASH  = 8'h02;

    localparam logic [NIB_W-1:0] NIB_BLANK = 4'hE;
    localparam logic [NIB_W-1:0] NIB_DASH  = 4'hF;

    typedef struct packed {
        logic [SEG_W-1:0] tube_sel;
        logic [SEG_W-1:0] digit1;
        logic [SEG_W-1:0] digit2;
    } scan_out_t;

endpackage

// File: rtl/seg_scan_driver_seg7_decode.sv
// Combinational nibble to seven-segment decoder shared by display paths.
module seg7_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (nib_i)
            4'h0:      seg_c = SEG_0;
            4'h1:      seg_c = SEG_1;
            4'h2:      seg_c = SEG_2;
            4'h3:      seg_c = SEG_3;
            4'h4:      seg_c = SEG_4;
            4'h5:      seg_c = SEG_5;
            4'h6:      seg_c = SEG_6;
            4'h7:      seg_c = SEG_7;
            4'h8:      seg_c = SEG_8;
            4'h9:      seg_c = SEG_9;
            4'hA:      seg_c = SEG_A;
            4'hB:      seg_c = SEG_B;
            4'hC:      seg_c = SEG_C;
            4'hD:      seg_c = SEG_D;
            NIB_BLANK: seg_c = SEG_BLANK;
            NIB_DASH:  seg_c = SEG_DASH;
            default:   seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner with per-frame word latching,
// per-digit blinking and a global enable.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES  = 100_000,
    parameter int unsigned BLINK_FRAMES = 62
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WORD_W-1:0]     time_data,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [SEG_W-1:0]      digit1,
    output logic [SEG_W-1:0]      digit2,
    output logic [SEG_W-1:0]      tube_sel
);

    localparam int unsigned CNT_W = $clog2(SCAN_CYCLES);
    localparam int unsigned FRM_W = $clog2(BLINK_FRAMES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [FRM_W-1:0]  frm_q, frm_d;
    logic              phase_q, phase_d;
    logic [WORD_W-1:0] shadow_q, shadow_d;
    scan_out_t         out_q, out_d;

    logic              tc;
    logic              frame_end;
    logic [NIB_W-1:0]  nib;
    logic [SEG_W-1:0]  seg;
    logic [SEG_W-1:0]  sel;
    logic              blank;

    seg7_decode u_decode (
        .nib_i (nib),
        .seg_c (seg)
    );

    // idx 0 is the leftmost digit, so it reads the top nibble of the shadow word.
    always_comb begin
        tc        = (cnt_q == CNT_LAST);
        frame_end = tc && (idx_q == 3'd7);
        nib       = shadow_q[{~idx_q, 2'b00} +: NIB_W];
        sel       = 8'h80 >> idx_q;
        blank     = !phase_q && |(blink_mask & sel);

        cnt_d    = tc ? '0 : cnt_q + CNT_W'(1);
        idx_d    = tc ? idx_q + 3'd1 : idx_q;
        shadow_d = frame_end ? time_data : shadow_q;
        frm_d    = frm_q;
        phase_d  = phase_q;
        if (frame_end) begin
            if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                phase_d = !phase_q;
            end else begin
                frm_d = frm_q + FRM_W'(1);
            end
        end

        out_d = '0;
        if (en) begin
            out_d.tube_sel = sel;
            if (!blank) begin
                if (!idx_q[2]) out_d.digit1 = seg;
                else           out_d.digit2 = seg;
            end
        end
    end

    // Reset keeps sampling the input word so the first frame shows current data.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            frm_q    <= '0;
            phase_q  <= 1'b1;
            shadow_q <= time_data;
            out_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            frm_q    <= frm_d;
            phase_q  <= phase_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
        end
    end

    assign tube_sel = out_q.tube_sel;
    assign digit1   = out_q.digit1;
    assign digit2   = out_q.digit2;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: stimulus pushes hand-derived expected outputs, a negedge monitor pops and compares.
module tb_seg_scan_driver;

    localparam int unsigned SC = 4;
    localparam int unsigned BF = 2;
    localparam int unsigned FRAME = 8 * SC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [31:0] time_data = 32'h00F03F00;
    logic [7:0]  blink_mask = 8'h00;
    logic [7:0]  digit1, digit2, tube_sel;

    typedef struct packed {
        logic [7:0] tube_sel;
        logic [7:0] digit1;
        logic [7:0] digit2;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Hand-written segment table, index = nibble value.
    logic [7:0] seg_tbl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h00, 8'h02};

    int          t = 0;          // cycles since reset release
    logic [31:0] cur_word;       // word the current frame displays

    seg_scan_driver #(.SCAN_CYCLES(SC), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .time_data  (time_data),
        .blink_mask (blink_mask),
        .digit1     (digit1),
        .digit2     (digit2),
        .tube_sel   (tube_sel)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int tt, input logic [31:0] w, input logic e,
                                   input logic [7:0] m, input logic r);
        exp_t x;
        int   k;
        logic off;
        logic [3:0] n;
        x = '0;
        if (r || !e) return x;
        k   = (tt / SC) % 8;
        off = (((tt / FRAME) / BF) % 2) == 1;
        n   = w[31 - 4*k -: 4];
        x.tube_sel = 8'h80 >> k;
        if (!(off && m[7-k])) begin
            if (k < 4) x.digit1 = seg_tbl[n];
            else       x.digit2 = seg_tbl[n];
        end
        return x;
    endfunction

    // One clock: expectation for the coming edge is queued at that edge.
    task automatic step();
        exp_t x;
        x = model(t, cur_word, en, blink_mask, rst);
        @(posedge clk);
        exp_q.push_back(x);
        if (rst) begin
            t = 0;
            cur_word = time_data;
        end else begin
            if ((t % FRAME) == FRAME - 1) cur_word = time_data;
            t++;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if ({tube_sel, digit1, digit2} !== e) begin
                n_fail++;
                $display("FAIL scan t=%0d: got sel=%h d1=%h d2=%h, want sel=%h d1=%h d2=%h",
                         t, tube_sel, digit1, digit2, e.tube_sel, e.digit1, e.digit2);
            end
        end
    end

    initial begin
        cur_word = time_data;
        #1;
        // Two reset cycles, then frame 0 shows 00F03F00.
        repeat (2) step();
        rst = 1'b0;
        repeat (FRAME) step();
        // Frame 1: change word while idx=3; it must not appear until frame 2.
        repeat (3 * SC) step();
        time_data = 32'h12345678;
        repeat (5 * SC) step();
        // Frame 2: queue A..F plus 9,8 for frame 3; enable blinking on tubes 3,2.
        blink_mask = 8'h0C;
        repeat (SC) step();
        time_data = 32'hABCDEF98;
        repeat (7 * SC) step();
        // Frames 3..4 with an en=0 pulse mid-frame 4.
        repeat (FRAME + 10) step();
        en = 1'b0;
        repeat (5) step();
        en = 1'b1;
        repeat (FRAME - 15) step();
        // Frame 5 then mid-frame reset at idx=5, cnt=2 of frame 6.
        time_data = 32'h01234567;
        repeat (FRAME + 5 * SC + 2) step();
        rst = 1'b1;
        time_data = 32'h89ABCDEF;
        step();
        rst = 1'b0;
        time_data = 32'h55555555;
        repeat (FRAME + SC) step();
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
